// File: rtl/rf_multiport_sb_if.sv
// Bus bundle for rf_multiport_sb: packed read ports, two write ports,
// scoreboard issue and bulk-clear control.
interface rf_multiport_sb_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int NUM_RD_PORTS = 2
);
  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr_i;
  logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data_o;
  logic [NUM_RD_PORTS-1:0]            rd_busy_o;

  logic                  wr0_en_i;
  logic [ADDR_WIDTH-1:0] wr0_addr_i;
  logic [DATA_WIDTH-1:0] wr0_data_i;
  logic                  wr1_en_i;
  logic [ADDR_WIDTH-1:0] wr1_addr_i;
  logic [DATA_WIDTH-1:0] wr1_data_i;

  logic                  issue_en_i;
  logic [ADDR_WIDTH-1:0] issue_addr_i;

  logic                  clr_i;
  logic                  clr_busy_o;

  modport master (
    output rd_addr_i, wr0_en_i, wr0_addr_i, wr0_data_i,
           wr1_en_i, wr1_addr_i, wr1_data_i, issue_en_i, issue_addr_i, clr_i,
    input  rd_data_o, rd_busy_o, clr_busy_o
  );

  modport slave (
    input  rd_addr_i, wr0_en_i, wr0_addr_i, wr0_data_i,
           wr1_en_i, wr1_addr_i, wr1_data_i, issue_en_i, issue_addr_i, clr_i,
    output rd_data_o, rd_busy_o, clr_busy_o
  );
endinterface

// File: rtl/rf_multiport_sb.sv
// Multi-port register file with prioritised writeback ports, optional
// write-to-read bypass, per-register busy scoreboard and sequential bulk clear.
module rf_multiport_sb #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGS     = 32,
  parameter int ADDR_WIDTH   = $clog2(NUM_REGS),
  parameter int NUM_RD_PORTS = 2,
  parameter int ZERO_REG     = 1,
  parameter int BYPASS       = 1
) (
  input logic               clk_i,
  input logic               rst_i,
  rf_multiport_sb_if.slave  bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  logic [0:0]            state_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;

  logic                  clearing;
  logic                  wr0_ok;
  logic                  wr1_ok;
  logic                  issue_ok;
  logic [ADDR_WIDTH-1:0] rd_addr;

  function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // Write ports, issue and bypass are all inert while the clear engine runs.
  assign clearing   = (state_q == ST_CLEAR);
  assign wr0_ok     = bus.wr0_en_i   && !clearing && !is_zero_reg(bus.wr0_addr_i);
  assign wr1_ok     = bus.wr1_en_i   && !clearing && !is_zero_reg(bus.wr1_addr_i);
  assign issue_ok   = bus.issue_en_i && !clearing && !is_zero_reg(bus.issue_addr_i);
  assign bus.clr_busy_o = clearing;

  // NOTE: the storage array is in the reset branch on purpose; architectural
  // state must read zero after reset, so this is not left to memory init.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
      busy_q    <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (clearing) begin
      regs_q[clr_cnt_q] <= '0;
      busy_q[clr_cnt_q] <= 1'b0;
      clr_cnt_q         <= clr_cnt_q + ADDR_WIDTH'(1);
      if (clr_cnt_q == LAST_IDX) state_q <= ST_IDLE;
    end else begin
      if (bus.clr_i) begin
        state_q   <= ST_CLEAR;
        clr_cnt_q <= '0;
      end
      // Later assignment wins, giving the load port priority on a collision.
      if (wr0_ok) regs_q[bus.wr0_addr_i] <= bus.wr0_data_i;
      if (wr1_ok) regs_q[bus.wr1_addr_i] <= bus.wr1_data_i;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (issue_ok && bus.issue_addr_i == ADDR_WIDTH'(i))
          busy_q[i] <= 1'b1;
        else if ((wr0_ok && bus.wr0_addr_i == ADDR_WIDTH'(i)) ||
                 (wr1_ok && bus.wr1_addr_i == ADDR_WIDTH'(i)))
          busy_q[i] <= 1'b0;
      end
    end
  end

  // NOTE: every signal written here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    bus.rd_data_o = '0;
    bus.rd_busy_o = '0;
    rd_addr       = '0;
    for (int k = 0; k < NUM_RD_PORTS; k++) begin
      rd_addr = bus.rd_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      if (is_zero_reg(rd_addr)) begin
        bus.rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = '0;
        bus.rd_busy_o[k]                          = 1'b0;
      end else if (BYPASS != 0 && wr1_ok && bus.wr1_addr_i == rd_addr) begin
        bus.rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = bus.wr1_data_i;
        bus.rd_busy_o[k]                          = 1'b0;
      end else if (BYPASS != 0 && wr0_ok && bus.wr0_addr_i == rd_addr) begin
        bus.rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = bus.wr0_data_i;
        bus.rd_busy_o[k]                          = 1'b0;
      end else begin
        bus.rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[rd_addr];
        bus.rd_busy_o[k]                          = busy_q[rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Self-checking bench for rf_multiport_sb: one bypassing and one non-bypassing
// instance driven with identical stimulus, expected data queued at drive time.
module tb_rf_multiport_sb;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int NP = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_multiport_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD_PORTS(NP)) bus_b ();
  rf_multiport_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD_PORTS(NP)) bus_n ();

  rf_multiport_sb #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD_PORTS(NP),
                    .ZERO_REG(1), .BYPASS(1)) dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b));
  rf_multiport_sb #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD_PORTS(NP),
                    .ZERO_REG(1), .BYPASS(0)) dut_n (.clk_i(clk), .rst_i(rst), .bus(bus_n));

  logic [DW-1:0] b_d0, b_d1, n_d0;
  logic          b_bz0, b_bz1, n_bz0;
  assign b_d0  = bus_b.rd_data_o[DW-1:0];
  assign b_d1  = bus_b.rd_data_o[2*DW-1:DW];
  assign n_d0  = bus_n.rd_data_o[DW-1:0];
  assign b_bz0 = bus_b.rd_busy_o[0];
  assign b_bz1 = bus_b.rd_busy_o[1];
  assign n_bz0 = bus_n.rd_busy_o[0];

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] model [NR];
  logic [DW-1:0] e;

  task automatic set_wr0(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus_b.wr0_en_i = en; bus_b.wr0_addr_i = a; bus_b.wr0_data_i = d;
    bus_n.wr0_en_i = en; bus_n.wr0_addr_i = a; bus_n.wr0_data_i = d;
  endtask

  task automatic set_wr1(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus_b.wr1_en_i = en; bus_b.wr1_addr_i = a; bus_b.wr1_data_i = d;
    bus_n.wr1_en_i = en; bus_n.wr1_addr_i = a; bus_n.wr1_data_i = d;
  endtask

  task automatic set_issue(input logic en, input logic [AW-1:0] a);
    bus_b.issue_en_i = en; bus_b.issue_addr_i = a;
    bus_n.issue_en_i = en; bus_n.issue_addr_i = a;
  endtask

  task automatic set_clr(input logic v);
    bus_b.clr_i = v; bus_n.clr_i = v;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus_b.rd_addr_i = {a1, a0}; bus_n.rd_addr_i = {a1, a0};
  endtask

  task automatic drive_idle();
    set_wr0(1'b0, '0, '0); set_wr1(1'b0, '0, '0); set_issue(1'b0, '0); set_clr(1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    set_rd(5'd5, 5'd9);
    #2;
    checks++; if (b_d0 !== '0 || b_d1 !== '0 || n_d0 !== '0) begin errors++;
      $display("FAIL reset_data: got %h/%h/%h expected 0", b_d0, b_d1, n_d0); end
    checks++; if (bus_b.rd_busy_o !== '0 || bus_n.rd_busy_o !== '0) begin errors++;
      $display("FAIL reset_busy: got %b/%b expected 0", bus_b.rd_busy_o, bus_n.rd_busy_o); end
    checks++; if (bus_b.clr_busy_o !== 1'b0) begin errors++;
      $display("FAIL reset_clr_busy: got %b expected 0", bus_b.clr_busy_o); end
    // Write held across an edge while reset is asserted: forwarded but not committed.
    set_wr0(1'b1, 5'd5, 32'h0000_00AA);
    @(posedge clk); #1;
    checks++; if (b_d0 !== 32'h0000_00AA || n_d0 !== '0) begin errors++;
      $display("FAIL reset_bypass: got %h/%h expected 000000aa/00000000", b_d0, n_d0); end
    set_wr0(1'b0, '0, '0);
    @(negedge clk); rst = 1'b0;
    next_cycle();
    @(negedge clk);
    checks++; if (b_d0 !== '0 || n_d0 !== '0) begin errors++;
      $display("FAIL reset_no_commit: got %h/%h expected 0", b_d0, n_d0); end
    next_cycle();
  endtask

  task automatic test_write();
    set_wr0(1'b1, 5'd5, 32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
    next_cycle();
    set_wr0(1'b0, '0, '0);
    set_rd(5'd5, 5'd5);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (b_d0 !== e || b_d1 !== e || n_d0 !== e) begin errors++;
      $display("FAIL write_x5: got %h/%h/%h expected %h", b_d0, b_d1, n_d0, e); end
    checks++; if (b_bz0 !== 1'b0 || b_bz1 !== 1'b0) begin errors++;
      $display("FAIL write_x5_busy: got %b%b expected 00", b_bz1, b_bz0); end
    next_cycle();
    set_wr0(1'b1, 5'd0, 32'h0000_1234);
    set_rd(5'd0, 5'd0);
    exp_q.push_back('0);
    @(negedge clk);
    checks++; if (b_d0 !== '0) begin errors++;
      $display("FAIL write_x0_bypass: got %h expected 0", b_d0); end
    next_cycle();
    set_wr0(1'b0, '0, '0);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (b_d0 !== e || n_d0 !== e) begin errors++;
      $display("FAIL write_x0: got %h/%h expected %h", b_d0, n_d0, e); end
    next_cycle();
  endtask

  task automatic test_conflict();
    set_wr0(1'b1, 5'd7, 32'h11);
    set_wr1(1'b1, 5'd7, 32'h22);
    set_rd(5'd7, 5'd7);
    exp_q.push_back(32'h22);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h22);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (b_d0 !== e) begin errors++;
      $display("FAIL conflict_bypass: got %h expected %h", b_d0, e); end
    e = exp_q.pop_front();
    checks++; if (n_d0 !== e) begin errors++;
      $display("FAIL conflict_nobypass_old: got %h expected %h", n_d0, e); end
    next_cycle();
    set_wr0(1'b0, '0, '0); set_wr1(1'b0, '0, '0);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (b_d0 !== e || n_d0 !== e) begin errors++;
      $display("FAIL conflict_stored: got %h/%h expected %h", b_d0, n_d0, e); end
    next_cycle();
  endtask

  task automatic test_scoreboard();
    set_issue(1'b1, 5'd3);
    next_cycle();
    set_issue(1'b0, '0);
    set_rd(5'd3, 5'd3);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (b_bz0 !== 1'b1 || b_bz1 !== 1'b1 || n_bz0 !== 1'b1) begin errors++;
        $display("FAIL sb_busy_idle%0d: got %b%b/%b expected 11/1", c, b_bz1, b_bz0, n_bz0); end
      next_cycle();
    end
    set_wr1(1'b1, 5'd3, 32'h55);
    exp_q.push_back(32'h55);
    @(negedge clk);
    checks++; if (b_bz0 !== 1'b0 || b_d0 !== 32'h55) begin errors++;
      $display("FAIL sb_wb_bypass: got busy %b data %h expected 0/00000055", b_bz0, b_d0); end
    checks++; if (n_bz0 !== 1'b1) begin errors++;
      $display("FAIL sb_wb_nobypass_busy: got %b expected 1", n_bz0); end
    next_cycle();
    set_wr1(1'b0, '0, '0);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (b_bz0 !== 1'b0 || n_bz0 !== 1'b0 || n_d0 !== e) begin errors++;
      $display("FAIL sb_after_wb: got busy %b/%b data %h expected 0/0 %h", b_bz0, n_bz0, n_d0, e); end
    next_cycle();
    set_issue(1'b1, 5'd3);
    set_wr0(1'b1, 5'd3, 32'h66);
    exp_q.push_back(32'h66);
    next_cycle();
    drive_idle();
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (b_bz0 !== 1'b1 || n_bz0 !== 1'b1 || b_d0 !== e) begin errors++;
      $display("FAIL sb_issue_wins: got busy %b/%b data %h expected 1/1 %h", b_bz0, n_bz0, b_d0, e); end
    next_cycle();
    set_wr0(1'b1, 5'd3, 32'h0);
    next_cycle();
    set_wr0(1'b0, '0, '0);
    set_issue(1'b1, 5'd0);
    set_rd(5'd0, 5'd0);
    next_cycle();
    set_issue(1'b0, '0);
    @(negedge clk);
    checks++; if (b_bz0 !== 1'b0 || b_bz1 !== 1'b0 || n_bz0 !== 1'b0 || b_d0 !== '0) begin errors++;
      $display("FAIL sb_issue_x0: got busy %b%b/%b data %h expected 00/0 0", b_bz1, b_bz0, n_bz0, b_d0); end
    next_cycle();
  endtask

  task automatic test_bulk_clear();
    int cyc;
    int high_cnt;
    model[0] = '0;
    for (int i = 1; i < NR; i++) begin
      model[i] = 32'h1000_0000 | (i * 32'h0101);
      if (i % 2 == 0) set_wr0(1'b1, AW'(i), model[i]);
      else            set_wr1(1'b1, AW'(i), model[i]);
      next_cycle();
      set_wr0(1'b0, '0, '0); set_wr1(1'b0, '0, '0);
    end
    for (int i = 1; i < NR; i++) begin
      set_rd(AW'(i), AW'(i));
      exp_q.push_back(model[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (b_d0 !== e || n_d0 !== e) begin errors++;
        $display("FAIL fill_x%0d: got %h/%h expected %h", i, b_d0, n_d0, e); end
      next_cycle();
    end
    set_issue(1'b1, 5'd6);
    next_cycle();
    set_issue(1'b0, '0);
    set_clr(1'b1);
    next_cycle();
    set_clr(1'b0);
    cyc = 0;
    high_cnt = 0;
    while (cyc < 64) begin
      if (cyc == 10) begin
        set_wr0(1'b1, 5'd4, 32'h99);
        set_rd(5'd4, 5'd20);
      end else if (cyc == 11) begin
        set_wr0(1'b0, '0, '0);
      end
      @(negedge clk);
      if (cyc == 10) begin
        checks++; if (b_d0 !== '0 || b_d1 !== model[20]) begin errors++;
          $display("FAIL clear_read_stored: got %h/%h expected 0/%h", b_d0, b_d1, model[20]); end
      end
      if (bus_b.clr_busy_o !== 1'b1) break;
      high_cnt++;
      next_cycle();
      cyc++;
    end
    checks++; if (high_cnt != NR) begin errors++;
      $display("FAIL clear_busy_cycles: got %0d expected %0d", high_cnt, NR); end
    for (int i = 0; i < NR; i++) model[i] = '0;
    // First cycle after clr_busy_o falls: a write here lands at the next edge.
    set_wr0(1'b1, 5'd8, 32'h77);
    model[8] = 32'h77;
    next_cycle();
    set_wr0(1'b0, '0, '0);
    for (int i = 0; i < NR; i++) begin
      set_rd(AW'(i), 5'd6);
      exp_q.push_back(model[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (b_d0 !== e || n_d0 !== e || b_bz0 !== 1'b0 || b_bz1 !== 1'b0) begin errors++;
        $display("FAIL after_clear_x%0d: got %h/%h busy %b%b expected %h busy 00",
                 i, b_d0, n_d0, b_bz1, b_bz0, e); end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_clear();
    set_wr0(1'b1, 5'd20, 32'hABCD);
    set_issue(1'b1, 5'd25);
    next_cycle();
    set_wr0(1'b0, '0, '0); set_issue(1'b0, '0);
    set_rd(5'd20, 5'd25);
    set_clr(1'b1);
    next_cycle();
    set_clr(1'b0);
    for (int c = 0; c < 9; c++) next_cycle();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus_b.clr_busy_o !== 1'b0 || bus_n.clr_busy_o !== 1'b0) begin errors++;
      $display("FAIL rst_mid_clear_drop: got %b/%b expected 0", bus_b.clr_busy_o, bus_n.clr_busy_o); end
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    next_cycle();
    @(negedge clk);
    checks++; if (bus_b.clr_busy_o !== 1'b0 || b_d0 !== '0 || b_bz1 !== 1'b0) begin errors++;
      $display("FAIL rst_mid_clear_state: got clr %b x20 %h busy25 %b expected 0/0/0",
               bus_b.clr_busy_o, b_d0, b_bz1); end
    for (int i = 0; i < NR; i++) begin
      set_rd(AW'(i), AW'(i));
      @(negedge clk);
      checks++; if (b_d0 !== '0 || n_d0 !== '0 || b_bz0 !== 1'b0) begin errors++;
        $display("FAIL rst_mid_clear_x%0d: got %h/%h busy %b expected 0", i, b_d0, n_d0, b_bz0); end
      next_cycle();
    end
    set_wr0(1'b1, 5'd9, 32'h5A5A_5A5A);
    exp_q.push_back(32'h5A5A_5A5A);
    next_cycle();
    set_wr0(1'b0, '0, '0);
    set_rd(5'd9, 5'd9);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (b_d0 !== e || n_d0 !== e) begin errors++;
      $display("FAIL rst_mid_clear_write: got %h/%h expected %h", b_d0, n_d0, e); end
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_conflict();
    test_scoreboard();
    test_bulk_clear();
    test_reset_mid_clear();
    checks++; if (exp_q.size() != 0) begin errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
